// File: rtl/bus_pkg.sv
// Shared constants and helpers for the bus device endpoint.
// The address field always sits in the top ADDR_W bits of a packet.
package bus_pkg;
  localparam int ADDR_W = 8;
  localparam int PKT_MAX_W = 64;
  localparam logic [ADDR_W-1:0] BROADCAST_DEF = 8'hFF;

  function automatic logic [ADDR_W-1:0] addr_of(input logic [PKT_MAX_W-1:0] pkt, input int pkt_w);
    addr_of = pkt[pkt_w-1 -: ADDR_W];
  endfunction
endpackage

// File: rtl/dev_fifo.sv
// First-word-fall-through FIFO with registered head, count and flags.
// A write while full is accepted only if a read retires the head in the same cycle.
module dev_fifo
  import bus_pkg::*;
#(
  parameter int width = 16,
  parameter int depth = 8
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_wr,
  input  logic [width-1:0]           i_din,
  input  logic                       i_rd,
  output logic [width-1:0]           o_dout,
  output logic [$clog2(depth+1)-1:0] o_count,
  output logic                       o_full,
  output logic                       o_empty
);
  localparam int PTR_W = $clog2(depth);
  localparam int CNT_W = $clog2(depth+1);

  logic [width-1:0] r_mem [depth];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] w_rd_ptr_nxt;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             r_full;
  logic             r_empty;
  logic [width-1:0] r_dout;
  logic [width-1:0] w_dout_nxt;
  logic             w_do_wr;
  logic             w_do_rd;

  assign w_do_rd      = i_rd && !r_empty;
  assign w_do_wr      = i_wr && (!r_full || i_rd);
  assign w_rd_ptr_nxt = r_rd_ptr + PTR_W'(1);

  // Occupancy after this edge.
  always_comb begin
    w_count_nxt = r_count;
    if (w_do_wr && !w_do_rd) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (!w_do_wr && w_do_rd) begin
      w_count_nxt = r_count - CNT_W'(1);
    end else begin
      w_count_nxt = r_count;
    end
  end

  // Head after this edge: the next stored entry, or a write landing in an emptying FIFO.
  always_comb begin
    w_dout_nxt = r_dout;
    if (w_do_rd) begin
      if (r_count > CNT_W'(1)) begin
        w_dout_nxt = r_mem[w_rd_ptr_nxt];
      end else if (w_do_wr) begin
        w_dout_nxt = i_din;
      end else begin
        w_dout_nxt = '0;
      end
    end else if (r_empty && w_do_wr) begin
      w_dout_nxt = i_din;
    end else begin
      w_dout_nxt = r_dout;
    end
  end

  // Storage array; stale contents are harmless because pointers reset.
  always_ff @(posedge i_clk) begin
    if (i_reset && w_do_wr) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  // Pointers, count, flags and head register.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_dout   <= '0;
    end else begin
      if (w_do_wr) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_rd) begin
        r_rd_ptr <= w_rd_ptr_nxt;
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_W'(depth));
      r_empty <= (w_count_nxt == CNT_W'(0));
      r_dout  <= w_dout_nxt;
    end
  end

  assign o_dout  = r_dout;
  assign o_count = r_count;
  assign o_full  = r_full;
  assign o_empty = r_empty;
endmodule

// File: rtl/bus_dev_endpoint.sv
// Device-side bus endpoint: TX FIFO toward the arbiter, address-filtered RX FIFO
// from it, saturating RX overflow counter and a pulse on pops of an empty TX.
module bus_dev_endpoint
  import bus_pkg::*;
#(
  parameter int               pckg_sz   = 16,
  parameter int               depth     = 8,
  parameter logic [ADDR_W-1:0] id        = 8'h00,
  parameter logic [ADDR_W-1:0] broadcast = BROADCAST_DEF
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_tx_wr,
  input  logic [pckg_sz-1:0] i_tx_data,
  output logic               o_tx_full,
  output logic               o_pndng,
  output logic [pckg_sz-1:0] o_D_pop,
  input  logic               i_pop,
  input  logic               i_push,
  input  logic [pckg_sz-1:0] i_D_push,
  input  logic               i_rx_rd,
  output logic               o_rx_valid,
  output logic [pckg_sz-1:0] o_rx_data,
  output logic [7:0]         o_drop_cnt,
  output logic               o_err_pop
);
  localparam int CNT_W = $clog2(depth+1);

  logic [CNT_W-1:0]  w_tx_count;
  logic              w_tx_full;
  logic              w_tx_empty;
  logic [CNT_W-1:0]  w_rx_count;
  logic              w_rx_full;
  logic              w_rx_empty;
  logic [ADDR_W-1:0] w_addr;
  logic              w_match;
  logic              w_rx_wr;
  logic              w_drop;
  logic              w_unused_counts;
  logic [7:0]        r_drop_cnt;
  logic              r_err_pop;

  dev_fifo #(.width(pckg_sz), .depth(depth)) u_tx_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_wr    (i_tx_wr),
    .i_din   (i_tx_data),
    .i_rd    (i_pop),
    .o_dout  (o_D_pop),
    .o_count (w_tx_count),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty)
  );

  dev_fifo #(.width(pckg_sz), .depth(depth)) u_rx_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_wr    (w_rx_wr),
    .i_din   (i_D_push),
    .i_rd    (i_rx_rd),
    .o_dout  (o_rx_data),
    .o_count (w_rx_count),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty)
  );

  // Non-matching packets never reach the RX FIFO and are not counted as drops.
  assign w_addr          = addr_of(PKT_MAX_W'(i_D_push), pckg_sz);
  assign w_match         = (w_addr == id) || (w_addr == broadcast);
  assign w_rx_wr         = i_push && w_match;
  assign w_drop          = w_rx_wr && w_rx_full && !i_rx_rd;
  assign w_unused_counts = ^{w_tx_count, w_rx_count};

  // Saturating RX overflow counter.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_drop_cnt <= 8'd0;
    end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  // One-cycle error pulse for a pop against an empty TX FIFO.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_err_pop <= 1'b0;
    end else begin
      r_err_pop <= i_pop && w_tx_empty;
    end
  end

  assign o_tx_full  = w_tx_full;
  assign o_pndng    = !w_tx_empty;
  assign o_rx_valid = !w_rx_empty;
  assign o_drop_cnt = r_drop_cnt;
  assign o_err_pop  = r_err_pop;
endmodule

// File: tb/tb_bus_dev_endpoint.sv
// Scoreboard bench for bus_dev_endpoint: directed scenarios then random traffic,
// with a negedge monitor comparing flags and every consumed packet.
module tb_bus_dev_endpoint;
  localparam int PW = 16;
  localparam int DEPTH = 8;
  localparam logic [7:0] ID = 8'h02;

  logic          clk;
  logic          i_reset;
  logic          i_tx_wr;
  logic [PW-1:0] i_tx_data;
  logic          o_tx_full;
  logic          o_pndng;
  logic [PW-1:0] o_D_pop;
  logic          i_pop;
  logic          i_push;
  logic [PW-1:0] i_D_push;
  logic          i_rx_rd;
  logic          o_rx_valid;
  logic [PW-1:0] o_rx_data;
  logic [7:0]    o_drop_cnt;
  logic          o_err_pop;

  bus_dev_endpoint #(.pckg_sz(PW), .depth(DEPTH), .id(ID), .broadcast(8'hFF)) dut (
    .i_clk      (clk),
    .i_reset    (i_reset),
    .i_tx_wr    (i_tx_wr),
    .i_tx_data  (i_tx_data),
    .o_tx_full  (o_tx_full),
    .o_pndng    (o_pndng),
    .o_D_pop    (o_D_pop),
    .i_pop      (i_pop),
    .i_push     (i_push),
    .i_D_push   (i_D_push),
    .i_rx_rd    (i_rx_rd),
    .o_rx_valid (o_rx_valid),
    .o_rx_data  (o_rx_data),
    .o_drop_cnt (o_drop_cnt),
    .o_err_pop  (o_err_pop)
  );

  always #5 clk = ~clk;

  // Reference state: occupancies, drop count, expected pulse, and packet scoreboards.
  int            tx_n = 0;
  int            rx_n = 0;
  int            m_drop = 0;
  bit            exp_err = 1'b0;
  bit            just_rst = 1'b0;
  bit            mon_en = 1'b0;
  logic [PW-1:0] tx_sb[$];
  logic [PW-1:0] rx_sb[$];
  int            n_checks = 0;
  int            n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: flags every cycle, packet data whenever the bus or host consumes a head.
  always @(negedge clk) begin
    if (mon_en) begin
      check("pndng", 32'(o_pndng), 32'(tx_n > 0));
      check("tx_full", 32'(o_tx_full), 32'(tx_n == DEPTH));
      check("rx_valid", 32'(o_rx_valid), 32'(rx_n > 0));
      check("drop_cnt", 32'(o_drop_cnt), 32'(m_drop));
      check("err_pop", 32'(o_err_pop), 32'(exp_err));
      if (just_rst) begin
        check("D_pop_after_reset", 32'(o_D_pop), 32'd0);
        check("rx_data_after_reset", 32'(o_rx_data), 32'd0);
      end
      if (i_reset && i_pop && o_pndng) begin
        if (tx_sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL D_pop: bus popped 0x%0h but no packet was expected at %0t", o_D_pop, $time);
        end else begin
          check("D_pop", 32'(o_D_pop), 32'(tx_sb.pop_front()));
        end
      end
      if (i_reset && i_rx_rd && o_rx_valid) begin
        if (rx_sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rx_data: host read 0x%0h but no packet was expected at %0t", o_rx_data, $time);
        end else begin
          check("rx_data", 32'(o_rx_data), 32'(rx_sb.pop_front()));
        end
      end
    end
  end

  // Drive one cycle of inputs and advance the reference model across the edge.
  task automatic step(input logic rst, input logic wr, input logic [PW-1:0] wd, input logic pp,
                      input logic ps, input logic [PW-1:0] pd, input logic rd);
    bit tx_pop_ok, tx_wr_ok, rx_match, rx_rd_ok, rx_wr_ok, drop, err;
    i_reset   = rst;
    i_tx_wr   = wr;
    i_tx_data = wd;
    i_pop     = pp;
    i_push    = ps;
    i_D_push  = pd;
    i_rx_rd   = rd;
    tx_pop_ok = pp && (tx_n > 0);
    tx_wr_ok  = wr && ((tx_n < DEPTH) || tx_pop_ok);
    rx_match  = ps && ((pd[15:8] == ID) || (pd[15:8] == 8'hFF));
    rx_rd_ok  = rd && (rx_n > 0);
    rx_wr_ok  = rx_match && ((rx_n < DEPTH) || rx_rd_ok);
    drop      = rx_match && (rx_n == DEPTH) && !rd;
    err       = pp && (tx_n == 0);
    @(posedge clk);
    #1;
    if (!rst) begin
      tx_n = 0;
      rx_n = 0;
      m_drop = 0;
      exp_err = 1'b0;
      just_rst = 1'b1;
      tx_sb.delete();
      rx_sb.delete();
    end else begin
      just_rst = 1'b0;
      tx_n = tx_n - int'(tx_pop_ok) + int'(tx_wr_ok);
      rx_n = rx_n - int'(rx_rd_ok) + int'(rx_wr_ok);
      if (tx_wr_ok) tx_sb.push_back(wd);
      if (rx_wr_ok) rx_sb.push_back(pd);
      if (drop && (m_drop < 255)) m_drop++;
      exp_err = err;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
  endtask

  initial begin
    clk = 1'b0;
    i_reset = 1'b0; i_tx_wr = 1'b0; i_tx_data = '0; i_pop = 1'b0;
    i_push = 1'b0; i_D_push = '0; i_rx_rd = 1'b0;
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
    mon_en = 1'b1;
    idle(1);

    // Basic TX ordering and drain.
    step(1'b1, 1'b1, 16'h0111, 1'b0, 1'b0, 16'h0, 1'b0);
    step(1'b1, 1'b1, 16'h0222, 1'b0, 1'b0, 16'h0, 1'b0);
    step(1'b1, 1'b1, 16'h0333, 1'b0, 1'b0, 16'h0, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);
    idle(1);

    // TX full: lone write dropped, write with pop accepted.
    for (int k = 0; k < DEPTH; k++) step(1'b1, 1'b1, 16'h1000 + 16'(k), 1'b0, 1'b0, 16'h0, 1'b0);
    step(1'b1, 1'b1, 16'h0999, 1'b0, 1'b0, 16'h0, 1'b0);
    step(1'b1, 1'b1, 16'h0AAA, 1'b1, 1'b0, 16'h0, 1'b0);
    for (int k = 0; k < DEPTH; k++) step(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);

    // Pop on empty TX: single error pulse.
    step(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);
    idle(2);

    // Address filter.
    step(1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 16'h02AA, 1'b0);
    step(1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 16'h03BB, 1'b0);
    step(1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 16'hFFCC, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1);

    // RX overflow, accept with simultaneous read, then saturation.
    for (int k = 0; k < DEPTH; k++) step(1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0240 + 16'(k), 1'b0);
    step(1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0201, 1'b0);
    step(1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 16'h02EE, 1'b1);
    for (int k = 0; k < 260; k++) step(1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 16'hFF00 + 16'(k), 1'b0);
    for (int k = 0; k < DEPTH; k++) step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1);

    // Reset with traffic in flight.
    for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 16'h5000 + 16'(k), 1'b0, 1'b0, 16'h0, 1'b0);
    step(1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0261, 1'b0);
    step(1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0262, 1'b0);
    step(1'b0, 1'b1, 16'h5555, 1'b1, 1'b1, 16'h0263, 1'b0);
    idle(2);

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      logic [7:0] a;
      case ($urandom_range(0, 3))
        0: a = ID;
        1: a = 8'h03;
        2: a = 8'hFF;
        default: a = 8'($urandom_range(0, 255));
      endcase
      step(1'b1 ^ ($urandom_range(0, 299) == 0),
           $urandom_range(0, 99) < 50, 16'($urandom_range(0, 65535)),
           $urandom_range(0, 99) < 45,
           $urandom_range(0, 99) < 55, {a, 8'($urandom_range(0, 255))},
           $urandom_range(0, 99) < 40);
    end
    idle(2);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
